// File: rtl/wb_write_arbiter.sv
// Write-back arbiter for the 64-bit LEGv8 register file: merges ALU results and
// buffered load results onto one write port and tracks pending writes for hazards.
module wb_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         issue_valid,
   input  logic [4:0]   issue_rd,
   input  logic         alu_valid,
   input  logic [4:0]   alu_rd,
   input  logic [W-1:0] alu_data,
   input  logic         mem_valid,
   input  logic [4:0]   mem_rd,
   input  logic [W-1:0] mem_data,
   output logic         mem_ready,
   input  logic [4:0]   ra1,
   input  logic [4:0]   ra2,
   output logic         hazard,
   output logic         we3,
   output logic [4:0]   wa3,
   output logic [W-1:0] wd3
);

   localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [4:0]  XZR  = 5'd31;

   // Load-result FIFO storage; entries for XZR never get here.
   logic [4:0]    r_fifo_rd   [DEPTH];
   logic [W-1:0]  r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic [31:0]   r_busy;

   logic          r_we;
   logic [4:0]    r_wa;
   logic [W-1:0]  r_wd;

   logic          w_alu_sel;
   logic          w_fifo_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_sel_vld;
   logic [4:0]    w_sel_rd;
   logic [W-1:0]  w_sel_data;
   logic [31:0]   w_busy_set;
   logic [31:0]   w_busy_clr;
   logic [31:0]   w_busy_nxt;

   assign w_fifo_empty = (r_count == '0);
   assign mem_ready    = !reset && (r_count != FULL);
   assign w_push       = mem_valid && mem_ready && (mem_rd != XZR);
   assign w_alu_sel    = alu_valid && (alu_rd != XZR);
   assign w_pop        = !w_alu_sel && !w_fifo_empty;

   // Arbitration: ALU has fixed priority, FIFO head fills idle slots.
   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      if (w_alu_sel) begin
         w_sel_vld  = 1'b1;
         w_sel_rd   = alu_rd;
         w_sel_data = alu_data;
      end else if (w_pop) begin
         w_sel_vld  = 1'b1;
         w_sel_rd   = r_fifo_rd[r_rd_ptr];
         w_sel_data = r_fifo_data[r_rd_ptr];
      end
   end

   // Set after clear so a new producer outranks a retiring one.
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      if (issue_valid && (issue_rd != XZR)) begin
         w_busy_set[issue_rd] = 1'b1;
      end
      if (w_sel_vld) begin
         w_busy_clr[w_sel_rd] = 1'b1;
      end
      w_busy_nxt     = (r_busy & ~w_busy_clr) | w_busy_set;
      w_busy_nxt[31] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= mem_rd;
         r_fifo_data[r_wr_ptr] <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Write-port stage: selection in one cycle becomes the regfile write in the next.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we <= 1'b0;
         r_wa <= '0;
         r_wd <= '0;
      end else begin
         r_we <= w_sel_vld;
         if (w_sel_vld) begin
            r_wa <= w_sel_rd;
            r_wd <= w_sel_data;
         end
      end
   end

   assign hazard = r_busy[ra1] | r_busy[ra2];
   assign we3    = r_we;
   assign wa3    = r_wa;
   assign wd3    = r_wd;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed cycle table from reset, then random
// traffic compared against a queue-based model of the write-back rules.
module tb_wb_write_arbiter;

   localparam int DEPTH = 4;
   localparam int W     = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         issue_valid;
   logic [4:0]   issue_rd;
   logic         alu_valid;
   logic [4:0]   alu_rd;
   logic [W-1:0] alu_data;
   logic         mem_valid;
   logic [4:0]   mem_rd;
   logic [W-1:0] mem_data;
   logic         mem_ready;
   logic [4:0]   ra1;
   logic [4:0]   ra2;
   logic         hazard;
   logic         we3;
   logic [4:0]   wa3;
   logic [W-1:0] wd3;

   wb_write_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .ra1(ra1), .ra2(ra2), .hazard(hazard),
      .we3(we3), .wa3(wa3), .wd3(wd3)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   typedef struct {
      bit          rst;
      bit          iv;
      logic [4:0]  ird;
      bit          av;
      logic [4:0]  ard;
      logic [63:0] ad;
      bit          mv;
      logic [4:0]  mrd;
      logic [63:0] md;
      logic [4:0]  r1;
      logic [4:0]  r2;
      bit          ewe;
      logic [4:0]  ewa;
      logic [63:0] ewd;
      bit          erdy;
      bit          ehz;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit rst, input bit iv, input logic [4:0] ird,
                      input bit av, input logic [4:0] ard, input logic [63:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input bit ewe, input logic [4:0] ewa, input logic [63:0] ewd,
                      input bit erdy, input bit ehz);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
      v.mv = mv; v.mrd = mrd; v.md = md; v.r1 = r1; v.r2 = r2;
      v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.erdy = erdy; v.ehz = ehz;
      vq.push_back(v);
   endtask

   task automatic drive(input bit rst, input bit iv, input logic [4:0] ird,
                        input bit av, input logic [4:0] ard, input logic [63:0] ad,
                        input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                        input logic [4:0] r1, input logic [4:0] r2);
      reset = rst; issue_valid = iv; issue_rd = ird;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      ra1 = r1; ra2 = r2;
   endtask

   task automatic tstep(input vec_t v, input int idx);
      drive(v.rst, v.iv, v.ird, v.av, v.ard, v.ad, v.mv, v.mrd, v.md, v.r1, v.r2);
      @(negedge clk);
      chk($sformatf("row%0d we3", idx), 64'(we3), 64'(v.ewe));
      chk($sformatf("row%0d wa3", idx), 64'(wa3), 64'(v.ewa));
      chk($sformatf("row%0d wd3", idx), wd3, v.ewd);
      chk($sformatf("row%0d mem_ready", idx), 64'(mem_ready), 64'(v.erdy));
      chk($sformatf("row%0d hazard", idx), 64'(hazard), 64'(v.ehz));
      @(posedge clk);
      #1;
   endtask

   // Reference model: load buffer as a queue, pending writes as a flag array.
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] d;
   } ent_t;

   ent_t        m_q[$];
   bit          m_busy[32];
   bit          m_we;
   logic [4:0]  m_wa;
   logic [63:0] m_wd;

   task automatic model_edge();
      ent_t        e;
      bit          sel;
      bit          rdy;
      logic [4:0]  srd;
      logic [63:0] sd;
      if (reset) begin
         m_q.delete();
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_we = 1'b0; m_wa = '0; m_wd = '0;
         return;
      end
      rdy = (m_q.size() != DEPTH);
      sel = 1'b0; srd = '0; sd = '0;
      if (alu_valid && alu_rd != 5'd31) begin
         sel = 1'b1; srd = alu_rd; sd = alu_data;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         sel = 1'b1; srd = e.rd; sd = e.d;
      end
      m_we = sel;
      if (sel) begin
         m_wa = srd; m_wd = sd; m_busy[srd] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd31) m_busy[issue_rd] = 1'b1;
      if (mem_valid && rdy && mem_rd != 5'd31) begin
         e.rd = mem_rd; e.d = mem_data;
         m_q.push_back(e);
      end
   endtask

   task automatic rstep(input bit do_chk);
      @(negedge clk);
      if (do_chk) begin
         chk("rnd we3", 64'(we3), 64'(m_we));
         chk("rnd wa3", 64'(wa3), 64'(m_wa));
         chk("rnd wd3", wd3, m_wd);
         chk("rnd mem_ready", 64'(mem_ready), 64'(!reset && (m_q.size() != DEPTH)));
         chk("rnd hazard", 64'(hazard), 64'(m_busy[ra1] | m_busy[ra2]));
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [4:0] pick_rd();
      return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
   endfunction

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;

      //  rst iv ird  av ard ad       mv mrd md        r1 r2  we wa wd       rdy hz
      add(1, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,        0, 0);
      add(0, 0, 0,   1, 5, 'h1234,   0, 0, 0,         0, 0,  0, 0, 0,        1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 5, 'h1234,   1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  0, 5, 'h1234,   1, 0);
      add(0, 1, 7,   0, 0, 0,        0, 0, 0,         7, 0,  0, 5, 'h1234,   1, 0);
      add(0, 0, 0,   0, 0, 0,        1, 7, 'hDEAD,    7, 0,  0, 5, 'h1234,   1, 1);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         7, 0,  0, 5, 'h1234,   1, 1);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         7, 0,  1, 7, 'hDEAD,   1, 0);
      add(0, 0, 0,   0, 0, 0,        1, 4, 'h44,      0, 0,  0, 7, 'hDEAD,   1, 0);
      add(0, 0, 0,   1, 3, 'h33,     0, 0, 0,         0, 0,  0, 7, 'hDEAD,   1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 3, 'h33,     1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 4, 'h44,     1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  0, 4, 'h44,     1, 0);
      add(0, 0, 0,   1, 9, 'h99,     1, 1, 'h101,     0, 0,  0, 4, 'h44,     1, 0);
      add(0, 0, 0,   1, 9, 'h99,     1, 2, 'h102,     0, 0,  1, 9, 'h99,     1, 0);
      add(0, 0, 0,   1, 9, 'h99,     1, 3, 'h103,     0, 0,  1, 9, 'h99,     1, 0);
      add(0, 0, 0,   1, 9, 'h99,     1, 4, 'h104,     0, 0,  1, 9, 'h99,     1, 0);
      add(0, 0, 0,   1, 9, 'h99,     1, 5, 'h105,     0, 0,  1, 9, 'h99,     0, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 9, 'h99,     0, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 1, 'h101,    1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 2, 'h102,    1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 3, 'h103,    1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  1, 4, 'h104,    1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  0, 4, 'h104,    1, 0);
      add(0, 1, 31,  1, 31, 'hFF,    1, 31, 'hAB,     31, 31, 0, 4, 'h104,   1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         31, 0, 0, 4, 'h104,    1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         0, 0,  0, 4, 'h104,    1, 0);
      add(0, 1, 12,  1, 10, 'hA0,    1, 11, 'hB1,     0, 0,  0, 4, 'h104,    1, 0);
      add(0, 0, 0,   1, 10, 'hA0,    1, 13, 'hB3,     12, 0, 1, 10, 'hA0,    1, 1);
      add(0, 0, 0,   1, 10, 'hA0,    1, 14, 'hB4,     12, 0, 1, 10, 'hA0,    1, 1);
      add(1, 0, 0,   1, 10, 'hA0,    0, 0, 0,         12, 0, 1, 10, 'hA0,    0, 1);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         12, 11, 0, 0, 0,       1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         11, 13, 0, 0, 0,       1, 0);
      add(0, 0, 0,   0, 0, 0,        0, 0, 0,         14, 0, 0, 0, 0,        1, 0);

      foreach (vq[i]) tstep(vq[i], i);

      // Random traffic against the model, starting from a reset edge.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rstep(0);
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) < 4), pick_rd(),
               ($urandom_range(0, 9) < 5), pick_rd(), {$urandom, $urandom},
               ($urandom_range(0, 9) < 6), pick_rd(), {$urandom, $urandom},
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         rstep(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
